// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
//   Write side of the byte-addressed instruction store read by the fetch stage.
//   32-bit words arrive over a valid/ready handshake. Each accepted word is
//   written big-endian, one byte per cycle, into an 8-bit-wide memory. Writing
//   starts at a word-aligned base address. A combinational 32-bit big-endian
//   read port lets fetch run from memory that is filled at run time.
//
//   Optional feature: define IMEM_LOADER_CHECKSUM_EN to add the `checksum`
//   output. It is the XOR of every word accepted in the current session.
//
// Ports
//   clk, rst          clock; synchronous active-high reset
//   start, base_addr  begin a session at {base_addr[AW-1:2],2'b00} (IDLE/DONE only)
//   wr_valid/wr_data/wr_last/wr_ready   word write handshake
//   busy, done, ovf   session status (ovf: memory full before wr_last)
//   byte_count        bytes written in the current session
//   checksum          XOR of accepted words (IMEM_LOADER_CHECKSUM_EN only)
//   rd_addr, rd_data  combinational big-endian word read; 0 if rd_addr+3 >= DEPTH
// -----------------------------------------------------------------------------
module imem_loader #(
    parameter int DEPTH = 152,
    parameter int AW    = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW-1:0] base_addr,
    input  logic          wr_valid,
    input  logic [31:0]   wr_data,
    input  logic          wr_last,
    output logic          wr_ready,
    output logic          busy,
    output logic          done,
    output logic          ovf,
    output logic [AW:0]   byte_count,
`ifdef IMEM_LOADER_CHECKSUM_EN
    output logic [31:0]   checksum,
`endif
    input  logic [31:0]   rd_addr,
    output logic [31:0]   rd_data
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_WRITE = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [AW:0]   ptr_q, ptr_d;      // one spare bit so ptr can reach DEPTH
    logic [AW:0]   cnt_q, cnt_d;
    logic [31:0]   shift_q, shift_d;
    logic          last_q, last_d;
    logic [1:0]    idx_q, idx_d;
    logic          done_q, done_d;
    logic          ovf_q, ovf_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [31:0]   csum_q, csum_d;
`endif

    logic [7:0]    mem [DEPTH];

    // Room for a whole word at ptr; compared in a wider width so ptr+4 cannot wrap.
    logic [AW+1:0] ptr_plus4;
    logic          room;
    assign ptr_plus4 = {1'b0, ptr_q} + (AW+2)'(4);
    assign room      = (ptr_plus4 <= (AW+2)'(DEPTH));

    logic start_ok;
    assign start_ok = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        last_d  = last_q;
        idx_d   = idx_q;
        done_d  = done_q;
        ovf_d   = ovf_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum_d  = csum_q;
`endif
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_ok) begin
                    ptr_d   = {1'b0, base_addr & ~AW'(3)};
                    cnt_d   = '0;
                    done_d  = 1'b0;
                    ovf_d   = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    csum_d  = '0;
`endif
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (!room) begin
                    // Memory exhausted before the last word: end the session.
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    ovf_d   = 1'b1;
                end else if (wr_valid) begin
                    shift_d = wr_data;
                    last_d  = wr_last;
                    idx_d   = 2'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    csum_d  = csum_q ^ wr_data;
`endif
                    state_d = ST_WRITE;
                end
            end
            default: begin // ST_WRITE
                shift_d = {shift_q[23:0], 8'h00};
                if (ptr_q < (AW+1)'(DEPTH)) begin
                    ptr_d = ptr_q + 1'b1;
                end
                cnt_d = cnt_q + 1'b1;
                idx_d = idx_q + 1'b1;
                if (idx_q == 2'd3) begin
                    if (last_q) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            shift_q <= '0;
            last_q  <= 1'b0;
            idx_q   <= 2'd0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            last_q  <= last_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q  <= csum_d;
`endif
        end
    end

    // Memory is never cleared; a reset edge only suppresses the pending write,
    // which is what aborts a session mid-word.
    logic mem_we;
    assign mem_we = (state_q == ST_WRITE) && !rst;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[ptr_q[AW-1:0]] <= shift_q[31:24];
        end
    end

    // Combinational read, widened by one bit so rd_addr near 2^32 cannot wrap.
    logic [32:0] rd_end;
    logic        rd_in_range;
    assign rd_end      = {1'b0, rd_addr} + 33'd3;
    assign rd_in_range = (rd_end < 33'(DEPTH));

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_rd_lane
            logic [AW-1:0] lane_addr;
            assign lane_addr = rd_addr[AW-1:0] + AW'(gi);
            assign rd_data[31-8*gi -: 8] = rd_in_range ? mem[lane_addr] : 8'h00;
        end
    endgenerate

    assign wr_ready   = (state_q == ST_LOAD) && room;
    assign busy       = (state_q == ST_LOAD) || (state_q == ST_WRITE);
    assign done       = done_q;
    assign ovf        = ovf_q;
    assign byte_count = cnt_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    assign checksum   = csum_q;
`endif

endmodule
